// File: rtl/ram_pkg.sv
// Shared constants for the single-port RAM: default geometry and the wr_rd
// command encodings.
package ram_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage : ram_pkg

// File: rtl/single_port_ram.sv
// Single-port register-array RAM. Reads and writes take one clock edge, and the
// read data is registered and qualified by out_en.
module single_port_ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_en
);

  if (DEPTH > 2**ADDR_WIDTH) begin : g_depth_check
    $error("single_port_ram: DEPTH (%0d) exceeds 2**ADDR_WIDTH (%0d)", DEPTH, 2**ADDR_WIDTH);
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  out_en_q, out_en_d;
  logic                  in_range;

  // Addresses at or beyond DEPTH have no storage: writes are dropped and reads return zero.
  always_comb begin
    in_range   = ({1'b0, addr} < DEPTH_L);
    data_out_d = data_out_q;
    out_en_d   = 1'b0;
    if (en && (wr_rd == RD)) begin
      out_en_d   = 1'b1;
      data_out_d = in_range ? mem_q[addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      data_out_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      out_en_q   <= out_en_d;
      if (en && (wr_rd == WR) && in_range) begin
        mem_q[addr] <= data_in;
      end
    end
  end

  assign data_out = data_out_q;
  assign out_en   = out_en_q;

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: a full-depth instance and a
// reduced-depth instance (DEPTH=6) run side by side against a word-array model.
module tb_single_port_ram;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int DA  = 8;
  localparam int DB  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] dout_a, dout_b;
  logic          oe_a, oe_b;

  int checks = 0;
  int errors = 0;

  int mem_a [DA];
  int mem_b [DB];
  int exp_dout_a, exp_dout_b;
  int exp_oe_a, exp_oe_b;

  always #5 clk = ~clk;

  single_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr),
    .data_in(data_in), .data_out(dout_a), .out_en(oe_a)
  );

  single_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr),
    .data_in(data_in), .data_out(dout_b), .out_en(oe_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " dout_a"}, int'(dout_a), exp_dout_a);
    check({tag, " oe_a"},   int'(oe_a),   exp_oe_a);
    check({tag, " dout_b"}, int'(dout_b), exp_dout_b);
    check({tag, " oe_b"},   int'(oe_b),   exp_oe_b);
  endtask

  task automatic model_reset();
    foreach (mem_a[i]) mem_a[i] = 0;
    foreach (mem_b[i]) mem_b[i] = 0;
    exp_dout_a = 0; exp_dout_b = 0;
    exp_oe_a = 0;   exp_oe_b = 0;
  endtask

  // One clock edge with the given access; model updated, then both instances checked.
  task automatic op(input string tag, input bit e, input bit w, input int a, input int d);
    en = e; wr_rd = w; addr = AW'(a); data_in = DW'(d);
    @(posedge clk);
    #1;
    if (!e) begin
      exp_oe_a = 0; exp_oe_b = 0;
    end else if (w) begin
      exp_oe_a = 0; exp_oe_b = 0;
      if (a < DA) mem_a[a] = d;
      if (a < DB) mem_b[a] = d;
    end else begin
      exp_oe_a = 1; exp_oe_b = 1;
      exp_dout_a = (a < DA) ? mem_a[a] : 0;
      exp_dout_b = (a < DB) ? mem_b[a] : 0;
    end
    check_all(tag);
  endtask

  initial begin
    int a, d;
    model_reset();

    rst = 1'b1;
    #1;
    check_all("reset_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset_release");

    for (int i = 0; i < 8; i++) op("read_after_reset", 1'b1, 1'b0, i, 8'h5A);

    op("wr3", 1'b1, 1'b1, 3, 8'hA5);
    op("rd3", 1'b1, 1'b0, 3, 8'h00);

    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 255));
      op("rand_wr", 1'b1, 1'b1, a, d);
      op("rand_rd", 1'b1, 1'b0, a, 0);
    end

    op("wr5_11", 1'b1, 1'b1, 5, 8'h11);
    op("wr5_22", 1'b1, 1'b1, 5, 8'h22);
    op("rd5", 1'b1, 1'b0, 5, 0);
    op("idle_hold", 1'b0, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    op("idle_hold2", 1'b0, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));

    op("wr1", 1'b1, 1'b1, 1, 8'h01);
    op("wr2", 1'b1, 1'b1, 2, 8'h02);
    op("wr3b", 1'b1, 1'b1, 3, 8'h03);
    op("burst_rd1", 1'b1, 1'b0, 1, 0);
    op("burst_rd2", 1'b1, 1'b0, 2, 0);
    op("burst_rd3", 1'b1, 1'b0, 3, 0);

    op("oor_wr6", 1'b1, 1'b1, 6, 8'h6C);
    op("oor_wr7", 1'b1, 1'b1, 7, 8'h7D);
    op("oor_rd6", 1'b1, 1'b0, 6, 0);
    op("oor_rd7", 1'b1, 1'b0, 7, 0);

    for (int i = 0; i < 12; i++) begin
      op("mix", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end

    // Reset lands mid-write and is held across the edge, so the write must not take effect.
    @(negedge clk);
    en = 1'b1; wr_rd = 1'b1; addr = 3'd7; data_in = 8'hFF;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_midwrite");
    @(posedge clk);
    #1;
    check_all("rst_held_edge");
    @(negedge clk);
    rst = 1'b0;
    op("rd7_after_rst", 1'b1, 1'b0, 7, 0);
    op("rd3_after_rst", 1'b1, 1'b0, 3, 0);
    op("wr0_first", 1'b1, 1'b1, 0, 8'h3C);
    op("rd0_first", 1'b1, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_single_port_ram
